// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
//==============================================================================
// Module      : if_fetch_unit_pkg
// Description : Shared fetch-stage defines (PC/instruction widths, reset PC,
//               instruction size) and small helpers.
// Revision    : 1.0 - initial release
//==============================================================================
package if_fetch_unit_pkg;

    localparam int          DEF_PC_WIDTH   = 32;
    localparam int          DEF_INST_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam int          INST_BYTES     = 4;

    // A fetch target is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
//==============================================================================
// Module      : if_fetch_unit_if
// Description : Fetch-stage bus: IMEM address/data, redirect request and the
//               valid/ready hand-off to decode.
// Revision    : 1.0 - initial release
//==============================================================================
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH   = DEF_PC_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH
);
    logic [PC_WIDTH-1:0]   imem_pc;
    logic [INST_WIDTH-1:0] imem_inst;
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  id_valid;
    logic                  id_ready;
    logic [PC_WIDTH-1:0]   id_pc;
    logic [INST_WIDTH-1:0] id_inst;
    logic                  id_misalign;

    // Fetch unit side
    modport master (
        output imem_pc, id_valid, id_pc, id_inst, id_misalign,
        input  imem_inst, redirect_valid, redirect_pc, id_ready
    );

    // Environment side (IMEM, branch unit, decode)
    modport slave (
        input  imem_pc, id_valid, id_pc, id_inst, id_misalign,
        output imem_inst, redirect_valid, redirect_pc, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_fifo.sv
`default_nettype none
//==============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO buffering fetched {pc, inst, misalign}
//               entries. Flush wins over push; push and pop may coincide at
//               any occupancy (the caller guarantees no overflow).
// Revision    : 1.0 - initial release
//==============================================================================
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  wire logic                       clk,
    input  wire logic                       reset_n,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    input  wire logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0]      o_count,
    output logic                            o_valid,
    output logic [WIDTH-1:0]                o_head
);
    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_pop;

    assign w_pop = i_pop & (r_count != '0);

    // Entry storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Read/write pointers and occupancy; flush empties the buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues one IMEM read per
//               cycle under a credit check, buffers responses in a FIFO and
//               hands {pc, inst, misalign} to decode. Redirect flushes.
// Revision    : 1.0 - initial release
//==============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH   = DEF_PC_WIDTH,
    parameter int                  INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEF_RESET_PC),
    parameter int                  FIFO_DEPTH = 2
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    if_fetch_unit_if.master bus
);
    localparam int c_ENTRY_W = PC_WIDTH + INST_WIDTH + 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_OCC_W   = c_CNT_W + 1;

    logic [PC_WIDTH-1:0]  r_pc_q;
    logic [PC_WIDTH-1:0]  r_rsp_pc;
    logic                 r_pending;
    logic                 r_halted;

    logic [c_CNT_W-1:0]   w_count;
    logic [c_OCC_W-1:0]   w_occupancy;
    logic                 w_head_valid;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic                 w_rsp_misalign;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic [c_ENTRY_W-1:0] w_head_data;

    assign w_pop          = w_head_valid & bus.id_ready;
    assign w_rsp_misalign = is_misaligned(r_rsp_pc[1:0]);
    // A response arriving during a redirect is dropped (flush also wins in the FIFO).
    assign w_push         = r_pending & ~bus.redirect_valid;
    assign w_push_data    = {r_rsp_pc, bus.imem_inst, w_rsp_misalign};

    // Entries held plus the read in flight, less the one leaving this cycle.
    assign w_occupancy = {1'b0, w_count} + c_OCC_W'(r_pending) - c_OCC_W'(w_pop);

    // The misaligned response being pushed this cycle already stops issue, so
    // exactly one misaligned entry reaches decode before the stage halts.
    assign w_issue = ~bus.redirect_valid & ~r_halted
                   & ~(r_pending & w_rsp_misalign)
                   & (w_occupancy < c_OCC_W'(FIFO_DEPTH));

    // PC, in-flight tracking and halt state; redirect has highest priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_q    <= RESET_PC;
            r_rsp_pc  <= '0;
            r_pending <= 1'b0;
            r_halted  <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc_q    <= bus.redirect_pc;
            r_pending <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_rsp_pc <= r_pc_q;
                r_pc_q   <= r_pc_q + PC_WIDTH'(INST_BYTES);
            end
            if (r_pending && w_rsp_misalign) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fetch_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_count     (w_count),
        .o_valid     (w_head_valid),
        .o_head      (w_head_data)
    );

    assign bus.imem_pc     = r_pc_q;
    assign bus.id_valid    = w_head_valid;
    assign bus.id_pc       = w_head_data[c_ENTRY_W-1 -: PC_WIDTH];
    assign bus.id_inst     = w_head_data[INST_WIDTH:1];
    assign bus.id_misalign = w_head_data[0];

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_if_fetch_unit
// Description : Self-checking bench for if_fetch_unit: directed scenarios plus
//               a randomized run against a stream-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    if_fetch_unit_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

    if_fetch_unit #(
        .PC_WIDTH   (32),
        .INST_WIDTH (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Byte-addressed IMEM contents derived from the address.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'd2654435761;
        return h[31:24] ^ a[7:0];
    endfunction

    // Little-endian word read starting at any byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Registered IMEM: data for the address one cycle later.
    always @(posedge clk) bus.imem_inst <= mem_word(bus.imem_pc);

    // Drive one cycle's inputs at the falling edge.
    task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        n_vec++;
        if (bus.id_valid !== 1'b0 || bus.id_misalign !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs got v=%b m=%b pc=%h inst=%h exp all zero",
                     bus.id_valid, bus.id_misalign, bus.id_pc, bus.id_inst);
        end
        n_vec++;
        if (bus.imem_pc !== DEF_RESET_PC) begin
            n_err++;
            $display("FAIL reset_imem_pc got=%h exp=%h", bus.imem_pc, DEF_RESET_PC);
        end
    endtask

    // Release reset with ready high; first entry after the 2nd edge, then 0,4,8,12.
    task automatic test_stream();
        cyc(1'b1, 1'b0, 32'h0);
        reset_n = 1'b1;
        n_vec++;
        if (bus.id_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_c0_valid got=%b exp=0", bus.id_valid);
        end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++;
        if (bus.id_valid !== 1'b0 || bus.imem_pc !== 32'd4) begin
            n_err++; $display("FAIL stream_c1 got v=%b imem_pc=%h exp v=0 imem_pc=4", bus.id_valid, bus.imem_pc);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * k) || bus.id_inst !== mem_word(32'(4 * k))) begin
                n_err++;
                $display("FAIL stream_w%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", k,
                         bus.id_valid, bus.id_pc, bus.id_inst, 32'(4 * k), mem_word(32'(4 * k)));
            end
        end
    endtask

    // Stall 5 cycles: two entries held (16, 20), imem_pc frozen at 24; then resume.
    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd16 || bus.imem_pc !== 32'd24) begin
                n_err++;
                $display("FAIL bp_stall%0d got v=%b pc=%h imem_pc=%h exp v=1 pc=10 imem_pc=18",
                         i, bus.id_valid, bus.id_pc, bus.imem_pc);
            end
        end
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(16 + 4 * k) || bus.id_inst !== mem_word(32'(16 + 4 * k))) begin
                n_err++;
                $display("FAIL bp_resume%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.id_valid, bus.id_pc, 32'(16 + 4 * k));
            end
        end
    endtask

    // Redirect to 0x40 with the FIFO full; the pop in that cycle is honoured.
    task automatic test_redirect_full();
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        n_vec++;
        if (bus.id_pc !== 32'd40 || bus.imem_pc !== 32'd48) begin
            n_err++; $display("FAIL redir_prefull got pc=%h imem_pc=%h exp 28/30", bus.id_pc, bus.imem_pc);
        end
        cyc(1'b1, 1'b1, 32'h40);
        n_vec++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'd40) begin
            n_err++; $display("FAIL redir_pop got v=%b pc=%h exp v=1 pc=28", bus.id_valid, bus.id_pc);
        end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++;
        if (bus.id_valid !== 1'b0 || bus.imem_pc !== 32'h40) begin
            n_err++; $display("FAIL redir_n1 got v=%b imem_pc=%h exp v=0 imem_pc=40", bus.id_valid, bus.imem_pc);
        end
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++;
        if (bus.id_valid !== 1'b0) begin
            n_err++; $display("FAIL redir_n2 got v=%b exp 0", bus.id_valid);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(32'h40 + 4 * k) || bus.id_inst !== mem_word(32'(32'h40 + 4 * k))) begin
                n_err++;
                $display("FAIL redir_n%0d got v=%b pc=%h exp v=1 pc=%h", k + 3, bus.id_valid, bus.id_pc, 32'(32'h40 + 4 * k));
            end
        end
    endtask

    // Misaligned target yields one flagged entry, then silence until redirect.
    task automatic test_misalign();
        cyc(1'b1, 1'b1, 32'h42);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        n_vec++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h42 || bus.id_misalign !== 1'b1 || bus.id_inst !== mem_word(32'h42)) begin
            n_err++;
            $display("FAIL mis_entry got v=%b pc=%h m=%b inst=%h exp v=1 pc=42 m=1 inst=%h",
                     bus.id_valid, bus.id_pc, bus.id_misalign, bus.id_inst, mem_word(32'h42));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b0) begin
                n_err++; $display("FAIL mis_halt%0d got v=%b pc=%h exp v=0", i, bus.id_valid, bus.id_pc);
            end
        end
        cyc(1'b1, 1'b1, 32'h80);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(32'h80 + 4 * k) || bus.id_misalign !== 1'b0) begin
                n_err++;
                $display("FAIL mis_resume%0d got v=%b pc=%h m=%b exp v=1 pc=%h m=0",
                         k, bus.id_valid, bus.id_pc, bus.id_misalign, 32'(32'h80 + 4 * k));
            end
        end
    endtask

    // PC increment wraps modulo 2^32.
    task automatic test_wrap();
        logic [31:0] exp_pc [2];
        exp_pc[0] = 32'hFFFF_FFFC;
        exp_pc[1] = 32'h0000_0000;
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_pc[k] || bus.id_inst !== mem_word(exp_pc[k])) begin
                n_err++;
                $display("FAIL wrap%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.id_valid, bus.id_pc, exp_pc[k]);
            end
        end
    endtask

    // Asynchronous reset mid-stream clears everything at once; fetch restarts at RESET_PC.
    task automatic test_reset_mid();
        repeat (3) cyc(1'b1, 1'b0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_inst !== 32'h0 ||
            bus.id_misalign !== 1'b0 || bus.imem_pc !== DEF_RESET_PC) begin
            n_err++;
            $display("FAIL rst_mid got v=%b pc=%h inst=%h m=%b imem_pc=%h exp all zero",
                     bus.id_valid, bus.id_pc, bus.id_inst, bus.id_misalign, bus.imem_pc);
        end
        repeat (2) cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            n_vec++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'(4 * k)) begin
                n_err++; $display("FAIL rst_restart%0d got v=%b pc=%h exp v=1 pc=%h", k, bus.id_valid, bus.id_pc, 32'(4 * k));
            end
        end
    endtask

    // Random ready/redirect traffic against a stream model: after a redirect,
    // decode sees target, target+4, ... from the 3rd following cycle on, with no
    // gaps, and nothing after a misaligned entry has been taken.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic        exp_v;
        logic        mis_seen;
        int          since;
        cyc(1'b1, 1'b1, 32'h100);
        exp_next = 32'h100;
        since    = 0;
        mis_seen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 7))
                0:       tgt = ($urandom() & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
                1:       tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: tgt = $urandom() & 32'h0000_FFFC;
            endcase
            cyc(rdy, rv, tgt);
            if (since < 1000) since++;
            exp_v = (since >= 3) && !mis_seen;
            n_vec++;
            if (bus.id_valid !== exp_v) begin
                n_err++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus.id_valid, exp_v);
            end
            if (exp_v && bus.id_valid === 1'b1) begin
                n_vec++;
                if (bus.id_pc !== exp_next || bus.id_inst !== mem_word(exp_next) ||
                    bus.id_misalign !== (exp_next[1:0] != 2'b00)) begin
                    n_err++;
                    $display("FAIL rand_entry cyc=%0d got pc=%h inst=%h m=%b exp pc=%h inst=%h m=%b", c,
                             bus.id_pc, bus.id_inst, bus.id_misalign, exp_next, mem_word(exp_next),
                             (exp_next[1:0] != 2'b00));
                end
            end
            if (exp_v && rdy) begin
                if (exp_next[1:0] != 2'b00) mis_seen = 1'b1;
                exp_next = exp_next + 32'd4;
            end
            if (rv) begin
                exp_next = tgt;
                since    = 0;
                mis_seen = 1'b0;
            end
        end
    endtask

    initial begin
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_random();
        cyc(1'b0, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule
`default_nettype wire
